// File: rtl/i_fetch.sv
// Instruction fetch stage: drives the instruction memory read port and
// presents fetched words in a single IF/ID slot, with a one-word skid
// buffer for responses that arrive while the slot is stalled and a flush
// state that drains a read left in flight by a redirect.
module i_fetch #(
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        pc_load_i,
  input  logic [31:0] pc_target_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_ir_o,
  output logic [31:0] if_next_pc_o
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {FETCH, BUFFERED, FLUSH} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] req_q;
  logic [31:0] buf_q;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic        slot_free;

  assign slot_free = ~out_valid | ~stall_i;

  // FLUSH keeps presenting the abandoned address until its response drains.
  always_comb begin
    imem_read    = 1'b0;
    imem_address = pc_q;
    case (state)
      FETCH: begin
        imem_read    = 1'b1;
        imem_address = pc_q;
      end
      FLUSH: begin
        imem_read    = 1'b1;
        imem_address = req_q;
      end
      default: begin
        imem_read    = 1'b0;
        imem_address = pc_q;
      end
    endcase
    if (rst) imem_read = 1'b0;
  end

  // Redirect outranks stall and response; otherwise a stalled response
  // parks in buf_q and pc_q already points past it, so it replays at pc_q-4.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      req_q     <= RESET_PC;
      buf_q     <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_ir    <= NOP;
    end else begin
      case (state)
        FETCH: begin
          req_q <= pc_q;
          if (pc_load_i) begin
            pc_q      <= pc_target_i;
            out_valid <= 1'b0;
            state     <= imem_resp ? FETCH : FLUSH;
          end else if (imem_resp) begin
            pc_q <= pc_q + 32'd4;
            if (slot_free) begin
              out_ir    <= imem_rdata;
              out_pc    <= pc_q;
              out_valid <= 1'b1;
            end else begin
              buf_q <= imem_rdata;
              state <= BUFFERED;
            end
          end else if (!stall_i) begin
            out_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (pc_load_i) begin
            pc_q      <= pc_target_i;
            out_valid <= 1'b0;
            state     <= FETCH;
          end else if (!stall_i) begin
            out_ir    <= buf_q;
            out_pc    <= pc_q - 32'd4;
            out_valid <= 1'b1;
            state     <= FETCH;
          end
        end
        FLUSH: begin
          if (pc_load_i) begin
            pc_q      <= pc_target_i;
            out_valid <= 1'b0;
          end else if (!stall_i) begin
            out_valid <= 1'b0;
          end
          if (imem_resp) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign if_valid_o   = out_valid;
  assign if_pc_o      = out_pc;
  assign if_ir_o      = out_ir;
  assign if_next_pc_o = out_pc + 32'd4;

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: a table of per-cycle vectors with
// hand-computed post-edge outputs, plus a 3-cycle-latency memory sequence.
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall_i;
  logic        pc_load_i;
  logic [31:0] pc_target_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_ir_o;
  logic [31:0] if_next_pc_o;

  int tests = 0;
  int fails = 0;

  i_fetch #(.RESET_PC(32'h40000060)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall_i      (stall_i),
    .pc_load_i    (pc_load_i),
    .pc_target_i  (pc_target_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_ir_o      (if_ir_o),
    .if_next_pc_o (if_next_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ld;
    logic [31:0] tgt;
    logic        resp;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ir;
  } vec_t;

  vec_t vt[27];

  function automatic vec_t mk(logic r, logic s, logic l, logic [31:0] t,
                              logic rp, logic [31:0] d, logic rd,
                              logic [31:0] a, logic v, logic [31:0] pc,
                              logic [31:0] ir);
    vec_t x;
    x.rst = r; x.stall = s; x.ld = l; x.tgt = t; x.resp = rp; x.rdata = d;
    x.rd = rd; x.addr = a; x.v = v; x.pc = pc; x.ir = ir;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; pc_load_i = 1'b0; pc_target_i = '0;
    imem_resp = 1'b0; imem_rdata = '0;

    //          rst st ld target        resp rdata         rd addr          v  pc            ir
    vt[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h40000060, 0, 32'h0,        32'h00000013);
    vt[1]  = mk(0, 0, 0, 32'h0,        1, 32'h40000060, 1, 32'h40000064, 1, 32'h40000060, 32'h40000060);
    vt[2]  = mk(0, 0, 0, 32'h0,        1, 32'h40000064, 1, 32'h40000068, 1, 32'h40000064, 32'h40000064);
    vt[3]  = mk(0, 1, 0, 32'h0,        1, 32'h40000068, 0, 32'h4000006C, 1, 32'h40000064, 32'h40000064);
    vt[4]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h4000006C, 1, 32'h40000064, 32'h40000064);
    vt[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4000006C, 1, 32'h40000068, 32'h40000068);
    vt[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4000006C, 0, 32'h40000068, 32'h40000068);
    vt[7]  = mk(0, 0, 0, 32'h0,        1, 32'h4000006C, 1, 32'h40000070, 1, 32'h4000006C, 32'h4000006C);
    vt[8]  = mk(0, 0, 1, 32'h40000100, 0, 32'h0,        1, 32'h40000070, 0, 32'h4000006C, 32'h4000006C);
    vt[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40000070, 0, 32'h4000006C, 32'h4000006C);
    vt[10] = mk(0, 0, 0, 32'h0,        1, 32'hDEADBEEF, 1, 32'h40000100, 0, 32'h4000006C, 32'h4000006C);
    vt[11] = mk(0, 0, 0, 32'h0,        1, 32'h40000100, 1, 32'h40000104, 1, 32'h40000100, 32'h40000100);
    vt[12] = mk(0, 1, 1, 32'h40000200, 1, 32'h40000104, 1, 32'h40000200, 0, 32'h40000100, 32'h40000100);
    vt[13] = mk(0, 0, 0, 32'h0,        1, 32'h40000200, 1, 32'h40000204, 1, 32'h40000200, 32'h40000200);
    vt[14] = mk(0, 0, 1, 32'h12345677, 0, 32'h0,        1, 32'h40000204, 0, 32'h40000200, 32'h40000200);
    vt[15] = mk(0, 0, 1, 32'h80000000, 0, 32'h0,        1, 32'h40000204, 0, 32'h40000200, 32'h40000200);
    vt[16] = mk(0, 0, 0, 32'h0,        1, 32'h11111111, 1, 32'h80000000, 0, 32'h40000200, 32'h40000200);
    vt[17] = mk(0, 0, 0, 32'h0,        1, 32'hAAAA5555, 1, 32'h80000004, 1, 32'h80000000, 32'hAAAA5555);
    vt[18] = mk(0, 0, 1, 32'h12345677, 1, 32'h22222222, 1, 32'h12345677, 0, 32'h80000000, 32'hAAAA5555);
    vt[19] = mk(0, 0, 0, 32'h0,        1, 32'h00000011, 1, 32'h1234567B, 1, 32'h12345677, 32'h00000011);
    vt[20] = mk(0, 0, 1, 32'hFFFFFFFC, 1, 32'h33333333, 1, 32'hFFFFFFFC, 0, 32'h12345677, 32'h00000011);
    vt[21] = mk(0, 0, 0, 32'h0,        1, 32'h00000005, 1, 32'h00000000, 1, 32'hFFFFFFFC, 32'h00000005);
    vt[22] = mk(0, 1, 0, 32'h0,        1, 32'h00000000, 0, 32'h00000004, 1, 32'hFFFFFFFC, 32'h00000005);
    vt[23] = mk(0, 1, 1, 32'h40000300, 0, 32'h0,        1, 32'h40000300, 0, 32'hFFFFFFFC, 32'h00000005);
    vt[24] = mk(0, 0, 0, 32'h0,        1, 32'h40000300, 1, 32'h40000304, 1, 32'h40000300, 32'h40000300);
    vt[25] = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h40000060, 0, 32'h0,        32'h00000013);
    vt[26] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40000060, 0, 32'h0,        32'h00000013);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst = vt[i].rst; stall_i = vt[i].stall; pc_load_i = vt[i].ld;
      pc_target_i = vt[i].tgt; imem_resp = vt[i].resp; imem_rdata = vt[i].rdata;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d read", i), {31'b0, imem_read}, {31'b0, vt[i].rd});
      chk($sformatf("v%0d addr", i), imem_address, vt[i].addr);
      chk($sformatf("v%0d valid", i), {31'b0, if_valid_o}, {31'b0, vt[i].v});
      chk($sformatf("v%0d pc", i), if_pc_o, vt[i].pc);
      chk($sformatf("v%0d ir", i), if_ir_o, vt[i].ir);
      chk($sformatf("v%0d next_pc", i), if_next_pc_o, vt[i].pc + 32'd4);
    end

    // Memory answering on the fourth cycle of each read.
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b0; pc_load_i = 1'b0; imem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] a;
        a = 32'h40000060 + 32'(4 * k);
        imem_resp  = (c == 3);
        imem_rdata = a;
        #1;
        chk($sformatf("lat k%0d c%0d read", k, c), {31'b0, imem_read}, 32'd1);
        chk($sformatf("lat k%0d c%0d addr", k, c), imem_address, a);
        @(posedge clk);
        #1;
        chk($sformatf("lat k%0d c%0d valid", k, c), {31'b0, if_valid_o},
            {31'b0, c == 3});
        if (c == 3) chk($sformatf("lat k%0d pc", k), if_pc_o, a);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
